mem_access: RTL and testbench

Multi-cycle LC-3 memory access sequencer that sits between the control unit and the memory port. It owns MAR and MDR, runs one read or write per request, and waits on the memory ready (R) handshake with a bounded timeout. On a read, it emits a one-cycle load strobe and data so the downstream 16-bit destination register (IR, MDR consumer or register-file entry) captures the result.

---
 rtl/mem_access.sv | 148 ++++++++++++++
 tb/tb_mem_access.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: LC-3 memory access sequencer. It owns MAR and MDR, runs one
// read or write per request, and waits on the memory ready handshake with a
// bounded timeout. It reports each result with a one-cycle response and load strobe.
module mem_access #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ld_en
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        mar;
  logic [15:0]        mdr;
  logic               we_q;
  logic               err_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               at_limit_c;

  // Last permitted ACCESS cycle reached
  assign at_limit_c = (wait_cnt == CNT_W'(MAX_WAIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ready wins over timeout on the limit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_r || at_limit_c) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: MAR/MDR capture, wait counter and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar      <= 16'h0000;
      mdr      <= 16'h0000;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mar      <= req_addr;
            mdr      <= req_wdata;
            we_q     <= req_we;
            wait_cnt <= '0;
            err_q    <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (mem_r) begin
            if (!we_q) begin
              mdr <= mem_rdata;
            end
            err_q <= 1'b0;
          end else if (at_limit_c) begin
            err_q <= 1'b1;
            if (!we_q) begin
              mdr <= 16'h0000;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore output decode from registered state only
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    ld_en     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        ld_en     = ~we_q & ~err_q;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign rsp_rdata = mdr;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver predicts each response from the
// access rules and queues it, and a negedge monitor checks each DUT response against the queue.
module tb_mem_access;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_r;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        ld_en;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [15:0] rdata;
    logic        ld;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          n_cmp;
  int          n_bad;

  mem_access #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_r     (mem_r),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest queued prediction
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("ld_en", 32'(ld_en), 32'(e.ld));
        end
      end else begin
        chk("ld_en_idle", 32'(ld_en), 32'd0);
      end
    end
  end

  // Leave DONE and check the IDLE outputs
  task automatic idle_gap();
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
  endtask

  // One access with mem_r rising on ACCESS cycle w (w > MAX_WAIT means never).
  // Starts at a negedge in IDLE (early=0) or DONE (early=1); returns at the DONE negedge.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rd_hit, input int w, input bit early);
    int unsigned a;
    exp_t        e;
    bit          last;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    mem_r     = 1'b0;
    if (early) begin
      @(negedge clk);
      chk("held_req_ready", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    a = cyc;
    for (int k = 0; k <= int'(MAX_WAIT); k++) begin
      chk("acc_mem_en", 32'(mem_en), 32'd1);
      chk("acc_mem_we", 32'(mem_we), 32'(we));
      chk("acc_mem_addr", 32'(mem_addr), 32'(addr));
      chk("acc_mem_wdata", 32'(mem_wdata), 32'(wdata));
      chk("acc_req_ready", 32'(req_ready), 32'd0);
      mem_r     = (k == w);
      mem_rdata = (k == w) ? rd_hit : 16'($urandom);
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      last      = (k == w) || (k == int'(MAX_WAIT));
      if (last) begin
        e.cyc   = a + 32'(k) + 1;
        e.err   = (w > k);
        e.rdata = we ? wdata : (e.err ? 16'h0000 : rd_hit);
        e.ld    = !we && !e.err;
        exp_q.push_back(e);
      end
      @(negedge clk);
      if (last) break;
    end
    mem_r     = 1'b0;
    mem_rdata = 16'($urandom);
  endtask

  initial begin
    int unsigned t0;
    bit          early;
    cyc       = 0;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    mem_rdata = 16'h0000;
    mem_r     = 1'b0;

    // Reset with random inputs
    repeat (4) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      mem_r     = 1'($urandom);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_ld_en", 32'(ld_en), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    mem_r     = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_mem_en", 32'(mem_en), 32'd0);

    // Zero-wait read
    do_req(1'b0, 16'h3000, 16'h5555, 16'h1234, 0, 1'b0);
    idle_gap();
    // Wait-state write
    do_req(1'b1, 16'hFE00, 16'hBEEF, 16'h7777, 3, 1'b0);
    idle_gap();
    // Timeout read
    do_req(1'b0, 16'h4000, 16'h1111, 16'hAAAA, 99, 1'b0);
    idle_gap();
    // Ready on the limit cycle wins, then a request held through DONE
    do_req(1'b0, 16'h5000, 16'h2222, 16'hC0DE, int'(MAX_WAIT), 1'b0);
    do_req(1'b0, 16'h5001, 16'h3333, 16'hD00D, 1, 1'b1);
    idle_gap();
    // Timeout write keeps the written data
    do_req(1'b1, 16'h6000, 16'h4444, 16'hEEEE, 99, 1'b0);
    idle_gap();

    // Reset in the middle of an access
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h7123;
    req_wdata = 16'h9876;
    @(negedge clk);
    req_valid = 1'b0;
    mem_r     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_en_before", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_en", 32'(mem_en), 32'd0);
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 16'h8000, 16'h0001, 16'h4321, 2, 1'b0);

    // Randomized traffic
    early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      early = 1'($urandom);
      if (!early) idle_gap();
      do_req(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, MAX_WAIT + 3)), early);
    end
    idle_gap();

    t0 = cyc;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (cyc == t0) $display("FAIL clock_stalled: got cycle %0d, expected progress", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on total run time
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
